line_clear_ctrl: RTL and testbench

Sequential controller for clearing completed rows on the Tetris board. After a piece locks, the game logic pulses `start`. The block captures the 400-bit board, scans it bottom-up one row per cycle, and collapses every full row by shifting the rows above it down. It then returns the compacted board and the number of rows removed, which the score logic consumes. It is the scheduled, multi-cycle replacement for a single-cycle row check between the lock stage and the score/display stages.

---
 rtl/line_clear_ctrl_pkg.sv | 20 ++
 rtl/line_clear_ctrl_if.sv | 36 +++
 rtl/line_clear_ctrl_row_full_sel.sv | 29 ++
 rtl/line_clear_ctrl.sv | 111 +++++++++++
 tb/tb_line_clear_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// Shared Tetris board definitions: board geometry, row-slice convention and
// the row-clear controller state encoding.
package tetris_pkg;

  localparam int unsigned BOARD_W = 20;
  localparam int unsigned BOARD_H = 20;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } clr_state_t;

  // Row y of a flattened board occupies bits [row_lsb(y, w) +: w]; row 0 is the top.
  function automatic int unsigned row_lsb(input int unsigned y, input int unsigned w);
    return y * w;
  endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Handshake/data bundle between the game logic (master) and the row-clear
// controller (slave).
interface line_clear_ctrl_if
  import tetris_pkg::*;
#(
  parameter int unsigned W  = BOARD_W,
  parameter int unsigned H  = BOARD_H,
  parameter int unsigned CW = $clog2(H + 1)
);

  logic             start;
  logic [W*H-1:0]   matrix_in;
  logic             busy;
  logic             done;
  logic [W*H-1:0]   matrix_out;
  logic [CW-1:0]    lines_cleared;

  modport master (
    output start,
    output matrix_in,
    input  busy,
    input  done,
    input  matrix_out,
    input  lines_cleared
  );

  modport slave (
    input  start,
    input  matrix_in,
    output busy,
    output done,
    output matrix_out,
    output lines_cleared
  );

endinterface

// File: rtl/line_clear_ctrl_row_full_sel.sv
// Selects board row i_y and reports whether every cell in it is occupied.
// Out-of-range row indices select an empty row, so they never read as full.
module row_full_sel
  import tetris_pkg::*;
#(
  parameter int unsigned W  = BOARD_W,
  parameter int unsigned H  = BOARD_H,
  parameter int unsigned YW = 5
) (
  input  logic [W*H-1:0] i_board,
  input  logic [YW-1:0]  i_y,
  output logic           o_full
);

  logic [W-1:0] w_row;

  // Row multiplexer indexed by the scan pointer.
  always_comb begin
    w_row = '0;
    for (int unsigned r = 0; r < H; r++) begin
      if (i_y == YW'(r)) begin
        w_row = i_board[row_lsb(r, W) +: W];
      end
    end
  end

  assign o_full = &w_row;

endmodule

// File: rtl/line_clear_ctrl.sv
// Multi-cycle completed-row clearer. Captures the board on start, scans rows
// bottom-up one per cycle, collapses each full row by shifting everything
// above it down one row, then presents the compacted board and removed-row
// count with a one-cycle done pulse.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned W  = BOARD_W,
  parameter int unsigned H  = BOARD_H,
  parameter int unsigned CW = $clog2(H + 1)
) (
  input  logic             clk,
  input  logic             reset,
  line_clear_ctrl_if.slave bus
);

  localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned NB = W * H;

  clr_state_t    r_state;
  logic [NB-1:0] r_work;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;
  logic [NB-1:0] r_matrix_out;
  logic [CW-1:0] r_lines;

  logic          w_full;
  logic [NB-1:0] w_shifted;

  row_full_sel #(
    .W  (W),
    .H  (H),
    .YW (YW)
  ) u_row_full_sel (
    .i_board (r_work),
    .i_y     (r_y),
    .o_full  (w_full)
  );

  // Shift network: rows at or above the pointer take the row above them;
  // row 0 is always at or above the pointer, so it simply empties.
  for (genvar gr = 0; gr < H; gr++) begin : g_shift
    if (gr == 0) begin : g_top
      assign w_shifted[0 +: W] = '0;
    end else begin : g_row
      assign w_shifted[gr*W +: W] = (YW'(gr) <= r_y) ? r_work[(gr-1)*W +: W]
                                                     : r_work[gr*W +: W];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_work       <= '0;
      r_y          <= YW'(H - 1);
      r_count      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_matrix_out <= '0;
      r_lines      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_work  <= bus.matrix_in;
            r_y     <= YW'(H - 1);
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_full) begin
            r_state <= SHIFT;
          end else if (r_y == '0) begin
            // Results are loaded on entry to DONE so they are valid during the done cycle.
            r_matrix_out <= r_work;
            r_lines      <= r_count;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_y <= r_y - 1'b1;
          end
        end
        SHIFT: begin
          r_work  <= w_shifted;
          r_count <= r_count + 1'b1;
          r_state <= SCAN;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.matrix_out    = r_matrix_out;
  assign bus.lines_cleared = r_lines;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: stimulus pushes expected results
// from a row-filter reference model; a negedge monitor checks busy every
// cycle and compares each done against the queue head.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int unsigned W  = 20;
  localparam int unsigned H  = 20;
  localparam int unsigned CW = $clog2(H + 1);
  localparam int unsigned NB = W * H;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  line_clear_ctrl_if #(.W(W), .H(H), .CW(CW)) bus ();

  line_clear_ctrl #(.W(W), .H(H), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NB-1:0] m;
    int unsigned   k;
    int unsigned   at;
  } exp_t;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
  } win_t;

  exp_t sbq[$];
  win_t wins[$];

  // Reference: keep non-full rows in bottom-up order, restack them from the bottom.
  function automatic void model(input logic [NB-1:0] b, output logic [NB-1:0] o,
                                output int unsigned k);
    logic [W-1:0] kept[$];
    logic [W-1:0] row;
    k = 0;
    o = '0;
    for (int y = H - 1; y >= 0; y--) begin
      row = b[y*W +: W];
      if (row == {W{1'b1}}) k++;
      else kept.push_back(row);
    end
    for (int i = 0; i < kept.size(); i++) o[(H-1-i)*W +: W] = kept[i];
  endfunction

  function automatic logic [NB-1:0] rand_bits();
    logic [NB-1:0] b;
    for (int i = 0; i < NB; i += 32) b[i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [NB-1:0] rand_board();
    logic [NB-1:0] b;
    b = rand_bits();
    for (int y = 0; y < H; y++) begin
      case ($urandom_range(0, 3))
        0: b[y*W +: W] = '1;
        1: b[y*W +: W] = '0;
        default: ;
      endcase
    end
    return b;
  endfunction

  // Monitor: busy window check every cycle, done checked against scoreboard.
  exp_t mon_e;
  logic exp_busy;
  always @(negedge clk) begin
    if (!reset) begin
      exp_busy = 1'b0;
      foreach (wins[i]) if (cyc >= wins[i].lo && cyc <= wins[i].hi) exp_busy = 1'b1;
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
      end
      if (bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done cyc=%0d got=1 exp=0", cyc);
        end else begin
          mon_e = sbq.pop_front();
          checks++;
          if (cyc != mon_e.at) begin
            errors++;
            $display("FAIL done_cycle got=%0d exp=%0d", cyc, mon_e.at);
          end
          checks++;
          if (bus.lines_cleared !== CW'(mon_e.k)) begin
            errors++;
            $display("FAIL lines_cleared cyc=%0d got=%0d exp=%0d", cyc, bus.lines_cleared, mon_e.k);
          end
          checks++;
          if (bus.matrix_out !== mon_e.m) begin
            errors++;
            $display("FAIL matrix_out cyc=%0d got=%h exp=%h", cyc, bus.matrix_out, mon_e.m);
          end
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
        mon_e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL missing_done cyc=%0d got=none exp_at=%0d", cyc, mon_e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.matrix_out !== '0 ||
        bus.lines_cleared !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b lines=%0d out_nonzero=%b exp all zero",
               tag, bus.busy, bus.done, bus.lines_cleared, |bus.matrix_out);
    end
  endtask

  // Records an accepted pass; returns its expected done cycle.
  task automatic record(input logic [NB-1:0] b, output int unsigned dcyc);
    exp_t e;
    win_t w;
    model(b, e.m, e.k);
    dcyc = cyc + H + 2 * e.k;
    e.at = dcyc;
    sbq.push_back(e);
    w.lo = cyc;
    w.hi = dcyc;
    wins.push_back(w);
  endtask

  // Issue one pass from an idle cycle; optionally re-pulse start mid-pass.
  task automatic run_pass(input logic [NB-1:0] b, input bit repulse);
    int unsigned d;
    bus.start = 1'b1;
    bus.matrix_in = b;
    tick();
    record(b, d);
    bus.start = 1'b0;
    bus.matrix_in = rand_bits();
    if (repulse) begin
      repeat (4) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    while (cyc < d + 1) tick();
  endtask

  logic [NB-1:0] brd;
  int unsigned d1, d2;

  initial begin
    bus.start = 1'b0;
    bus.matrix_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_idle_outputs("reset_state");
    repeat (5) begin
      tick();
      check_idle_outputs("idle_after_reset");
    end

    // Empty board.
    run_pass('0, 1'b0);

    // Bottom row full plus top-left cell.
    brd = '0;
    brd[NB-1 -: W] = '1;
    brd[0] = 1'b1;
    run_pass(brd, 1'b0);

    // Rows 16 and 18 full, 17 and 19 one cell short.
    brd = '0;
    brd[16*W +: W] = '1;
    brd[17*W +: W] = {{(W-1){1'b1}}, 1'b0};
    brd[18*W +: W] = '1;
    brd[19*W +: W] = {1'b0, {(W-1){1'b1}}};
    run_pass(brd, 1'b0);

    // Rows 16..19 full only.
    brd = '0;
    for (int y = 16; y < 20; y++) brd[y*W +: W] = '1;
    run_pass(brd, 1'b0);

    // All-ones board.
    run_pass('1, 1'b0);

    // Extra start pulse mid-pass must be ignored.
    run_pass('0, 1'b1);

    // Reset mid-pass aborts without done.
    brd = rand_board();
    bus.start = 1'b1;
    bus.matrix_in = brd;
    tick();
    record(brd, d1);
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    wins.delete();
    check_idle_outputs("after_mid_reset");
    repeat (30) tick();

    // Start held high: back-to-back passes.
    brd = rand_board();
    bus.start = 1'b1;
    bus.matrix_in = brd;
    tick();
    record(brd, d1);
    while (cyc < d1 + 2) tick();
    record(brd, d2);
    bus.start = 1'b0;
    while (cyc < d2 + 1) tick();

    // Reset together with start: start dropped.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.matrix_in = '1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    check_idle_outputs("reset_with_start");
    repeat (25) tick();

    // Randomized passes.
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      run_pass(rand_board(), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_done got=%0d exp=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
